// File: rtl/wb_stage.sv
// Writeback stage: accepts completed instructions from execute, formats load data,
// drives the register-file write port and publishes the in-flight rd for interlock.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_rd,
    input  logic [31:0]      ex_result,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_funct3,
    input  logic [1:0]       ex_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             w_en,
    output logic [4:0]       waddr,
    output logic [31:0]      wdata,
    output logic             hz_valid,
    output logic [4:0]       hz_rd,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic [4:0]       r_rd;
    logic [4:0]       r_waddr;
    logic [31:0]      r_result;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [CNT_W-1:0] r_count;

    logic             w_xfer;
    logic [31:0]      w_ext;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign ex_ready = (r_state != S_WAIT_MEM);
    assign w_xfer   = ex_valid && ex_ready;

    // Load formatting; reserved funct3 encodings fall through to a full word.
    always_comb begin
        w_byte = mem_rdata[8*r_addr_lo +: 8];
        w_half = mem_rdata[16*r_addr_lo[1] +: 16];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) w_next = ex_is_load ? S_WAIT_MEM : S_WRITE;
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_xfer) w_next = ex_is_load ? S_WAIT_MEM : S_WRITE;
                else        w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd      <= 5'd0;
            r_waddr   <= 5'd0;
            r_result  <= 32'd0;
            r_funct3  <= 3'd0;
            r_addr_lo <= 2'd0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_rd      <= ex_rd;
                r_funct3  <= ex_funct3;
                r_addr_lo <= ex_addr_lo;
                // A load leaves result/waddr untouched so the write port holds
                // the previous writeback while the memory response is pending.
                if (!ex_is_load) begin
                    r_result <= ex_result;
                    r_waddr  <= ex_rd;
                end
            end else if (r_state == S_WAIT_MEM && mem_rvalid) begin
                r_result <= w_ext;
                r_waddr  <= r_rd;
            end
            if (r_state == S_WRITE) r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_en     = (r_state == S_WRITE) && (r_rd != 5'd0);
    assign waddr    = r_waddr;
    assign wdata    = r_result;
    assign hz_valid = (r_state != S_IDLE) && (r_rd != 5'd0);
    assign hz_rd    = r_rd;
    assign wb_count = r_count;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the core, directly upstream of the register file. It accepts completed instructions from execute through a valid/ready handshake. For loads it waits for the data-memory response, then extracts and sign- or zero-extends the byte, halfword or word. It drives the register file write port (w_en, waddr, wdata) and publishes the in-flight destination register so decode can interlock.

Parameters:
CNT_W, 32, width of the retired-writeback counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute presents an instruction
ex_ready  out  1  stage accepts; transfer when ex_valid && ex_ready
ex_rd  in  5  destination register index
ex_result  in  32  ALU result (ignored for loads)
ex_is_load  in  1  instruction is a load
ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ex_addr_lo  in  2  load address bits [1:0]
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word
w_en  out  1  register file write enable
waddr  out  5  register file write address
wdata  out  32  register file write data
hz_valid  out  1  a destination register is in flight
hz_rd  out  5  in-flight destination index
wb_count  out  CNT_W  number of completed writebacks

Behaviour:
- States: IDLE, WAIT_MEM, WRITE (2-bit register). Reset (rst_n=0, asynchronous): state=IDLE, latched rd/result/funct3/addr_lo=0, wb_count=0.
- Reset values: w_en=0, waddr=0, wdata=0, hz_valid=0, hz_rd=0, ex_ready=1 (after reset deasserts).
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- ex_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM.
- On an accepted transfer, the stage latches rd, result, is_load, funct3 and addr_lo. Next state is WAIT_MEM if is_load, otherwise WRITE.
- IDLE with no transfer: stay in IDLE.
- WAIT_MEM: hold until mem_rvalid=1. On that edge, latch the extracted value into result and go to WRITE. mem_rvalid in IDLE or WRITE is ignored (stray response, no state change).
- WRITE lasts one cycle:
  - w_en = (rd != 0); waddr = rd; wdata = result.
  - wb_count increments by 1, including when rd=0.
  - Next state is IDLE, or WAIT_MEM/WRITE if a new transfer is accepted in the same cycle. This gives back-to-back ALU throughput of 1 per cycle.
- Outside WRITE: w_en=0. waddr and wdata hold their last values.
- Latency: an ALU op accepted at edge N shows w_en=1 in the cycle after edge N. A load writes in the cycle after the edge that samples mem_rvalid.
- hz_valid = 1 whenever state != IDLE and the latched rd != 0; hz_rd = latched rd. In WRITE, hz_valid is still 1 because the register file commits at the end of that cycle.
- Load extraction:
  - Byte = mem_rdata[8*addr_lo +: 8]; LB sign-extends from bit 7, LBU zero-extends.
  - Halfword = mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored. LH sign-extends from bit 15, LHU zero-extends.
  - LW takes the full word, addr_lo is ignored.
  - Reserved funct3 values (011, 110, 111) behave as LW.
- rd=0: the full handshake and counting still occur, but w_en stays 0, so x0 is never written.
- Reset mid-operation (WAIT_MEM or WRITE): immediate return to IDLE. The pending write is dropped and wb_count is cleared.
- wb_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-WAIT_MEM, then release -> w_en=0, hz_valid=0, wb_count=0, ex_ready=1 within the same cycle the reset asserts.
- ALU stream: three back-to-back ALU ops (rd=1/2/3, results 1000/2000/3000) -> w_en high for three consecutive cycles, waddr=1,2,3, wdata=1000,2000,3000, ex_ready constantly 1, wb_count=3.
- Load extraction: mem_rdata=0x80F1_7F82.
  - LB at addr_lo=0 -> 0xFFFFFF82; LBU at addr_lo=0 -> 0x00000082.
  - LB at addr_lo=1 -> 0x0000007F.
  - LH at addr_lo=2 -> 0xFFFF80F1; LHU at addr_lo=2 -> 0x000080F1.
  - LW -> 0x80F17F82.
- Load wait: load to rd=5, mem_rvalid delayed 4 cycles -> ex_ready=0 and hz_valid=1, hz_rd=5 throughout; no w_en until the cycle after mem_rvalid; a stray mem_rvalid pulse while in IDLE causes no write.
- x0 suppression: ALU op rd=0, result=0xDEADBEEF -> w_en stays 0, wb_count increments by 1, hz_valid stays 0.
- Counter wrap (CNT_W=4): 17 ALU ops -> wb_count reads 1.
